async_req_arbiter: RTL



---
 rtl/async_req_arbiter_pkg.sv | 37 +++
 rtl/sync.sv | 35 +++
 rtl/async_req_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/async_req_arbiter_pkg.sv
// Shared types and helpers for the asynchronous request arbiter.
// rr_pick is written against a fixed maximum width so other round-robin
// blocks can reuse it by zero-extending their request vectors.
package async_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int RrMaxReq = 32;
  localparam int RrIdxW   = $clog2(RrMaxReq);

  typedef struct packed {
    logic              found;
    logic [RrIdxW-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] scanning ptr, ptr+1, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [RrMaxReq-1:0] req,
                                       input int unsigned          ptr,
                                       input int unsigned          n);
    rr_pick_t          res;
    logic [RrIdxW-1:0] cand;
    res = '0;
    for (int unsigned i = 0; i < RrMaxReq; i++) begin
      cand = RrIdxW'((ptr + i) % n);
      if (i < n && !res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync.sv
// Multi-flop level synchronizer with async active-low reset and a
// synchronous clear that returns the chain to ResetValue.
module sync #(
  parameter int   Stages     = 2,
  parameter logic ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] chain_q;
  logic [Stages-1:0] chain_d;

  // Shift the asynchronous input one stage deeper each clock.
  always_comb begin
    chain_d = {chain_q[Stages-2:0], d_i};
  end

  // Chain register; clr_i lets a synchronous block reset flush stale levels.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= {Stages{ResetValue}};
    end else if (clr_i) begin
      chain_q <= {Stages{ResetValue}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_o = chain_q[Stages-1];

endmodule

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter for asynchronous 4-phase req/ack requesters.
// Each req bit is synchronized; the FSM grants one synchronized requester,
// holds ack until its req drops, then idles GuardCycles before regranting.
module async_req_arbiter import async_req_arbiter_pkg::*; #(
  parameter int NumReq      = 4,
  parameter int SyncStages  = 2,
  parameter int GuardCycles = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_i,
  output logic [NumReq-1:0]         ack_o,
  output logic                      gnt_valid_o,
  output logic [$clog2(NumReq)-1:0] gnt_idx_o,
  output logic                      busy_o
);

  localparam int IdxW   = $clog2(NumReq);
  localparam int GuardW = (GuardCycles > 1) ? $clog2(GuardCycles) : 1;

  logic [NumReq-1:0] req_s;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic [NumReq-1:0] ack_q, ack_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [IdxW-1:0]   gnt_idx_q, gnt_idx_d;

  rr_pick_t          pick;
  logic [IdxW-1:0]   pick_idx;

  // One synchronizer per requester; block reset flushes the chains.
  for (genvar i = 0; i < NumReq; i++) begin : g_sync
    sync #(
      .Stages    (SyncStages),
      .ResetValue(1'b0)
    ) u_sync (
      .clk_i (clk_i),
      .rst_ni(1'b1),
      .clr_i (rst_i),
      .d_i   (req_i[i]),
      .q_o   (req_s[i])
    );
  end

  // Round-robin candidate among synchronized requests.
  always_comb begin
    pick = rr_pick(RrMaxReq'(req_s), 32'(ptr_q), 32'(NumReq));
  end

  assign pick_idx = IdxW'(pick.idx);

  // Next-state logic: grant from IDLE, hold in GRANT, cool down in RELEASE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    guard_d     = guard_q;
    ack_d       = ack_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d         = GRANT;
          ack_d           = '0;
          ack_d[pick_idx] = 1'b1;
          gnt_valid_d     = 1'b1;
          gnt_idx_d       = pick_idx;
        end
      end
      GRANT: begin
        // Only the owner's level matters; other requests wait.
        if (!req_s[gnt_idx_q]) begin
          state_d     = RELEASE;
          ack_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_idx_d   = '0;
          ptr_d       = (gnt_idx_q == IdxW'(NumReq - 1)) ? '0 : gnt_idx_q + IdxW'(1);
          guard_d     = GuardW'(GuardCycles - 1);
        end
      end
      RELEASE: begin
        if (guard_q == '0) begin
          state_d = IDLE;
        end else begin
          guard_d = guard_q - GuardW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        ack_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
      end
    endcase
  end

  // State and output registers; reset drops ack even mid-transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      guard_q     <= '0;
      ack_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      guard_q     <= guard_d;
      ack_q       <= ack_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
    end
  end

  assign ack_o       = ack_q;
  assign gnt_valid_o = gnt_valid_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign busy_o      = (state_q != IDLE);

endmodule
